// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - event-code helpers, Gray-step decode and parameter checks for key_event_encoder
package kbd_pkg;

    localparam int DEB_SAMPLES_MIN = 2;
    localparam int DEB_SAMPLES_MAX = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_CW   = 2'b01,
        STEP_CCW  = 2'b10
    } step_e;

    function automatic bit params_ok(input int num_keys, input int num_enc,
                                     input int ev_w, input int deb_samples);
        return (num_keys + 2 * num_enc <= (1 << (ev_w - 1))) &&
               (deb_samples >= DEB_SAMPLES_MIN) && (deb_samples <= DEB_SAMPLES_MAX);
    endfunction

    function automatic int key_code(input int k, input bit press, input int ev_w);
        return (press ? (1 << (ev_w - 1)) : 0) + k;
    endfunction

    function automatic int enc_code(input int e, input bit cw, input int num_keys, input int ev_w);
        return (1 << (ev_w - 1)) + num_keys + 2 * e + (cw ? 0 : 1);
    endfunction

    // Clockwise successor in the 00 -> 01 -> 11 -> 10 -> 00 cycle
    function automatic logic [1:0] gray_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic step_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
        if (gray_next(prev) == cur)      return STEP_CW;
        else if (gray_next(cur) == prev) return STEP_CCW;
        else                             return STEP_NONE;
    endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// rtl/key_event_encoder_if.sv - event FIFO read/flush bus between the SPI reply path and key_event_encoder
interface key_event_encoder_if #(
    parameter int EV_W    = 8,
    parameter int FIFO_AW = 3
);
    logic              fifo_clr;
    logic              ev_rd;
    logic [EV_W-1:0]   ev_data;
    logic              ev_valid;
    logic [FIFO_AW:0]  ev_count;
    logic              ev_ovf;

    modport master (
        output fifo_clr, ev_rd,
        input  ev_data, ev_valid, ev_count, ev_ovf
    );

    modport slave (
        input  fifo_clr, ev_rd,
        output ev_data, ev_valid, ev_count, ev_ovf
    );
endinterface

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - first-word-fall-through event FIFO with flush, occupancy count and full read+write
module event_fifo #(
    parameter int EV_W    = 8,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_wr,
    input  logic               i_rd,
    input  logic [EV_W-1:0]    i_data,
    output logic [EV_W-1:0]    o_data,
    output logic               o_empty,
    output logic               o_full,
    output logic [FIFO_AW:0]   o_count
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [EV_W-1:0]    r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_rd;
    logic               w_do_wr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (FIFO_AW + 1)'(DEPTH));
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);
    // Head is masked while empty so the bus reads 0 after reset or flush
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_clr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - debounced keys and quadrature encoders arbitrated round-robin into an event FIFO
// Optional key auto-repeat is built when KEY_AUTOREPEAT_EN is defined.
module key_event_encoder
    import kbd_pkg::*;
#(
    parameter int NUM_KEYS    = 32,
    parameter int NUM_ENC     = 4,
    parameter int DEB_DIV_W   = 10,
    parameter int DEB_SAMPLES = 4,
    parameter int FIFO_AW     = 3,
    parameter int EV_W        = 8
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REP_DELAY   = 40,
    parameter int REP_PERIOD  = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [NUM_ENC-1:0]  enc_a,
    input  logic [NUM_ENC-1:0]  enc_b,
    key_event_encoder_if.slave  bus
);
    localparam int NUM_SRC = NUM_KEYS + NUM_ENC;
    localparam int SRC_W   = $clog2(NUM_SRC);

    if (!params_ok(NUM_KEYS, NUM_ENC, EV_W, DEB_SAMPLES)) begin : g_param_check
        $error("key_event_encoder: unsupported parameter set");
    end

    logic [NUM_KEYS-1:0]                  r_keys_s1, r_keys_s2;
    logic [NUM_ENC-1:0]                   r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic [DEB_DIV_W-1:0]                 r_div;
    logic                                 w_tick;
    logic [NUM_KEYS-1:0][DEB_SAMPLES-1:0] r_hist, w_hist_nxt;
    logic [NUM_KEYS-1:0]                  r_level, w_level_nxt;
    logic [NUM_KEYS-1:0]                  r_pend_press, w_press_nxt;
    logic [NUM_KEYS-1:0]                  r_pend_rel, w_rel_nxt;
    logic [NUM_ENC-1:0][1:0]              r_enc_prev, w_prev_nxt;
    logic signed [2:0]                    r_acc [NUM_ENC];
    logic signed [2:0]                    w_acc_nxt [NUM_ENC];
    logic                                 r_enc_loaded;
    logic                                 r_ovf, w_ovf_nxt;
    logic [SRC_W-1:0]                     r_ptr, w_gnt_idx;
    logic [NUM_SRC-1:0]                   w_src_pend, w_src_hi, w_gnt_oh;
    logic                                 w_gnt_vld, w_fire, w_full, w_empty;
    logic [EV_W-1:0]                      w_ev;

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_CW = 16;
    logic [NUM_KEYS-1:0] r_rep_oh, w_rep_oh_nxt;
    logic [REP_CW-1:0]   r_rep_cnt, w_rep_cnt_nxt;
    logic                w_rep_restart;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_oh  <= '0;
            r_rep_cnt <= '0;
        end else begin
            r_rep_oh  <= w_rep_oh_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end
`endif

    assign w_tick = &r_div;

    // Round-robin: lowest pending source at or above the pointer, else lowest overall
    always_comb begin
        w_src_pend = '0;
        w_src_hi   = '0;
        w_gnt_idx  = '0;
        w_gnt_oh   = '0;
        w_ev       = '0;
        for (int k = 0; k < NUM_KEYS; k++) w_src_pend[k] = r_pend_press[k] | r_pend_rel[k];
        for (int e = 0; e < NUM_ENC; e++)  w_src_pend[NUM_KEYS+e] = (r_acc[e] != 3'sd0);
        for (int i = 0; i < NUM_SRC; i++)  w_src_hi[i] = w_src_pend[i] && (SRC_W'(i) >= r_ptr);
        w_gnt_vld = |w_src_pend;
        for (int i = NUM_SRC - 1; i >= 0; i--) if (w_src_pend[i]) w_gnt_idx = SRC_W'(i);
        if (|w_src_hi) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) if (w_src_hi[i]) w_gnt_idx = SRC_W'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) w_gnt_oh[i] = w_gnt_vld && (w_gnt_idx == SRC_W'(i));
        for (int k = 0; k < NUM_KEYS; k++)
            if (w_gnt_oh[k]) w_ev = EV_W'(key_code(k, r_pend_press[k], EV_W));
        for (int e = 0; e < NUM_ENC; e++)
            if (w_gnt_oh[NUM_KEYS+e]) w_ev = EV_W'(enc_code(e, !r_acc[e][2], NUM_KEYS, EV_W));
    end

    assign w_fire = w_gnt_vld && (!w_full || bus.ev_rd);

    always_comb begin
        int    a;
        step_e st;
        a           = 0;
        st          = STEP_NONE;
        w_hist_nxt  = r_hist;
        w_level_nxt = r_level;
        w_press_nxt = r_pend_press;
        w_rel_nxt   = r_pend_rel;
        w_prev_nxt  = r_enc_prev;
        w_ovf_nxt   = r_ovf;
`ifdef KEY_AUTOREPEAT_EN
        w_rep_oh_nxt  = r_rep_oh;
        w_rep_cnt_nxt = r_rep_cnt;
        w_rep_restart = 1'b0;
`endif
        // Granted flag clears first so a fresh debounce edge in the same cycle survives
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (w_fire && w_gnt_oh[k]) begin
                if (r_pend_press[k]) w_press_nxt[k] = 1'b0;
                else                 w_rel_nxt[k]   = 1'b0;
            end
        end
        if (w_tick) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                w_hist_nxt[k] = {r_hist[k][DEB_SAMPLES-2:0], r_keys_s2[k]};
                if (w_hist_nxt[k] == {DEB_SAMPLES{~r_level[k]}}) begin
                    w_level_nxt[k] = ~r_level[k];
                    if (r_level[k]) begin
                        w_rel_nxt[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        w_rep_oh_nxt[k] = 1'b0;
`endif
                    end else begin
                        w_press_nxt[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        w_rep_oh_nxt    = '0;
                        w_rep_oh_nxt[k] = 1'b1;
                        w_rep_cnt_nxt   = REP_CW'(REP_DELAY);
                        w_rep_restart   = 1'b1;
`endif
                    end
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            if (!w_rep_restart && (|w_rep_oh_nxt)) begin
                if (r_rep_cnt <= REP_CW'(1)) begin
                    w_press_nxt   = w_press_nxt | r_rep_oh;
                    w_rep_cnt_nxt = REP_CW'(REP_PERIOD);
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt - REP_CW'(1);
                end
            end
`endif
        end
        for (int e = 0; e < NUM_ENC; e++) begin
            a = int'(r_acc[e]);
            if (w_fire && w_gnt_oh[NUM_KEYS+e]) a = (a > 0) ? a - 1 : a + 1;
            if (w_tick) begin
                w_prev_nxt[e] = {r_a_s2[e], r_b_s2[e]};
                st = r_enc_loaded ? gray_step(r_enc_prev[e], {r_a_s2[e], r_b_s2[e]}) : STEP_NONE;
                if (st == STEP_CW) begin
                    if (r_acc[e] == 3'sd3) w_ovf_nxt = 1'b1;
                    if (a < 3) a = a + 1;
                end else if (st == STEP_CCW) begin
                    if (r_acc[e] == -3'sd3) w_ovf_nxt = 1'b1;
                    if (a > -3) a = a - 1;
                end
            end
            w_acc_nxt[e] = 3'(a);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_keys_s1    <= '0;
            r_keys_s2    <= '0;
            r_a_s1       <= '0;
            r_a_s2       <= '0;
            r_b_s1       <= '0;
            r_b_s2       <= '0;
            r_div        <= '0;
            r_hist       <= '0;
            r_level      <= '0;
            r_pend_press <= '0;
            r_pend_rel   <= '0;
            r_enc_prev   <= '0;
            r_enc_loaded <= 1'b0;
            r_ovf        <= 1'b0;
            r_ptr        <= '0;
            for (int e = 0; e < NUM_ENC; e++) r_acc[e] <= '0;
        end else begin
            r_keys_s1    <= keys;
            r_keys_s2    <= r_keys_s1;
            r_a_s1       <= enc_a;
            r_a_s2       <= r_a_s1;
            r_b_s1       <= enc_b;
            r_b_s2       <= r_b_s1;
            r_div        <= r_div + 1'b1;
            r_hist       <= w_hist_nxt;
            r_level      <= w_level_nxt;
            r_pend_press <= w_press_nxt;
            r_pend_rel   <= w_rel_nxt;
            r_enc_prev   <= w_prev_nxt;
            r_enc_loaded <= r_enc_loaded | w_tick;
            r_ovf        <= bus.fifo_clr ? 1'b0 : w_ovf_nxt;
            r_acc        <= w_acc_nxt;
            if (w_fire) r_ptr <= (w_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
        end
    end

    event_fifo #(
        .EV_W    (EV_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.fifo_clr),
        .i_wr    (w_fire),
        .i_rd    (bus.ev_rd),
        .i_data  (w_ev),
        .o_data  (bus.ev_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (bus.ev_count)
    );

    assign bus.ev_valid = !w_empty;
    assign bus.ev_ovf   = r_ovf;
endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - directed self-checking bench for key_event_encoder
module tb_key_event_encoder;
    localparam int NK   = 32;
    localparam int NE   = 4;
    localparam int DIVW = 3;
    localparam int DS   = 4;
    localparam int AW   = 3;
    localparam int EW   = 8;
    localparam int TICK = 1 << DIVW;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic [NK-1:0] keys  = '0;
    logic [NE-1:0] enc_a = '0;
    logic [NE-1:0] enc_b = '0;
    int            n_checks = 0;
    int            n_fail   = 0;

    key_event_encoder_if #(.EV_W(EW), .FIFO_AW(AW)) bus ();

    key_event_encoder #(
        .NUM_KEYS    (NK),
        .NUM_ENC     (NE),
        .DEB_DIV_W   (DIVW),
        .DEB_SAMPLES (DS),
        .FIFO_AW     (AW),
        .EV_W        (EW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .keys  (keys),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TICK) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (bus.ev_valid !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.ev_valid), 32'd1);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        wait_valid(tag, 20 * TICK);
        chk(tag, 32'(bus.ev_data), 32'(exp));
        bus.ev_rd = 1'b1;
        @(negedge clk);
        bus.ev_rd = 1'b0;
    endtask

    task automatic set_enc(input int e, input logic [1:0] ab);
        enc_a[e] = ab[1];
        enc_b[e] = ab[0];
        wait_ticks(2);
    endtask

    initial begin
        bus.fifo_clr = 1'b0;
        bus.ev_rd    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_count", 32'(bus.ev_count), 32'd0);
        chk("rst_ovf",   32'(bus.ev_ovf),   32'd0);
        chk("rst_data",  32'(bus.ev_data),  32'd0);
        rst = 1'b1;
        wait_ticks(2);
        chk("idle_count", 32'(bus.ev_count), 32'd0);

        // key 5 press and release
        keys[5] = 1'b1;
        wait_valid("t1_first", 10 * TICK);
        chk("t1_count_first", 32'(bus.ev_count), 32'd1);
        chk("t1_head", 32'(bus.ev_data), 32'h85);
        wait_ticks(6);
        chk("t1_count_single", 32'(bus.ev_count), 32'd1);
        pop_expect("t1_press", 8'h85);
        chk("t1_empty", 32'(bus.ev_valid), 32'd0);
        keys[5] = 1'b0;
        wait_ticks(8);
        chk("t1_rel_count", 32'(bus.ev_count), 32'd1);
        pop_expect("t1_release", 8'h05);

        // two-tick glitch is filtered
        keys[5] = 1'b1;
        wait_ticks(2);
        keys[5] = 1'b0;
        wait_ticks(8);
        chk("t2_glitch_count", 32'(bus.ev_count), 32'd0);

        // encoder 1 clockwise through one full Gray cycle
        set_enc(1, 2'b01);
        set_enc(1, 2'b11);
        set_enc(1, 2'b10);
        set_enc(1, 2'b00);
        wait_ticks(2);
        chk("t3_count", 32'(bus.ev_count), 32'd4);
        for (int i = 0; i < 4; i++) pop_expect("t3_cw", 8'hA2);
        chk("t3_empty", 32'(bus.ev_valid), 32'd0);

        // ten keys at once into a depth-8 FIFO
        keys[9:0] = '1;
        wait_ticks(8);
        chk("t4_full_count", 32'(bus.ev_count), 32'd8);
        chk("t4_ovf", 32'(bus.ev_ovf), 32'd0);
        pop_expect("t4_pop0", 8'h80);
        pop_expect("t4_pop1", 8'h81);
        wait_ticks(1);
        chk("t4_refill_count", 32'(bus.ev_count), 32'd8);
        chk("t4_refill_head", 32'(bus.ev_data), 32'h82);
        chk("t4_ovf_after", 32'(bus.ev_ovf), 32'd0);

        // encoder 0 five steps CCW while full saturates and overflows
        set_enc(0, 2'b10);
        set_enc(0, 2'b11);
        set_enc(0, 2'b01);
        set_enc(0, 2'b00);
        set_enc(0, 2'b10);
        wait_ticks(1);
        chk("t5_ovf_set", 32'(bus.ev_ovf), 32'd1);
        chk("t5_count_full", 32'(bus.ev_count), 32'd8);
        bus.fifo_clr = 1'b1;
        @(negedge clk);
        bus.fifo_clr = 1'b0;
        chk("t5_clr_valid", 32'(bus.ev_valid), 32'd0);
        chk("t5_clr_count", 32'(bus.ev_count), 32'd0);
        chk("t5_clr_ovf",   32'(bus.ev_ovf),   32'd0);
        for (int i = 0; i < 3; i++) pop_expect("t5_ccw", 8'hA1);
        wait_ticks(2);
        chk("t5_drained", 32'(bus.ev_count), 32'd0);

        // asynchronous reset in the middle of a release burst
        keys = '0;
        wait_valid("t6_burst", 10 * TICK);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("t6_rst_count", 32'(bus.ev_count), 32'd0);
        chk("t6_rst_data",  32'(bus.ev_data),  32'd0);
        chk("t6_rst_ovf",   32'(bus.ev_ovf),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(10);
        chk("t6_quiet_valid", 32'(bus.ev_valid), 32'd0);
        chk("t6_quiet_count", 32'(bus.ev_count), 32'd0);
        keys[3] = 1'b1;
        pop_expect("t6_new_press", 8'h83);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/key_event_encoder.md
Name: key_event_encoder

Overview:
- Parametrised successor to the fixed 23-key keyboard reader and 7-entry event FIFO pair.
- Samples NUM_KEYS raw key lines and NUM_ENC quadrature encoders, then debounces the keys and decodes encoder steps.
- Arbitrates pending events round-robin into an internal first-word-fall-through FIFO.
- The FIFO is read by the SPI reply path; the command decoder can flush it.

Parameters:
- NUM_KEYS, 32: number of debounced key inputs (includes joystick and encoder push buttons).
- NUM_ENC, 4: number of quadrature encoders.
- DEB_DIV_W, 10: width of the sample-tick prescaler; one sample tick every 2**DEB_DIV_W clocks.
- DEB_SAMPLES, 4: number of consecutive equal samples needed to accept a key level (2..8).
- FIFO_AW, 3: FIFO address width; depth is 2**FIFO_AW.
- EV_W, 8: event code width.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous reset, active-low.
- keys, in, NUM_KEYS: raw key levels, 1 = pressed. Asynchronous to clk.
- enc_a, in, NUM_ENC: encoder phase A, raw.
- enc_b, in, NUM_ENC: encoder phase B, raw.
- fifo_clr, in, 1: synchronous FIFO flush, one-cycle pulse.
- ev_rd, in, 1: pop the head event.
- ev_data, out, EV_W: head event; valid while ev_valid = 1.
- ev_valid, out, 1: FIFO not empty.
- ev_count, out, FIFO_AW+1: current FIFO occupancy.
- ev_ovf, out, 1: sticky flag; cleared by fifo_clr.

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs are 0 and the FIFO is empty.
  - All debounced key levels are 0; all shift registers and pending flags are 0.
  - Encoder phase history is loaded from the synchronised inputs on the first tick after reset is released; no event is generated by that load.
- Input synchronisation: every raw input passes through a 2-flop synchroniser before any other logic.
- Prescaler: a free-running counter asserts tick for one clk every 2**DEB_DIV_W cycles.
- Key debounce:
  - On each tick, each key shifts its synchronised level into a DEB_SAMPLES-bit history.
  - The debounced level changes only when the whole history equals the inverse of the current level.
  - A 0->1 change sets pend_press[k]; a 1->0 change sets pend_rel[k].
  - If a key changes again before its earlier event is emitted, both flags may be set. Press is emitted first, then release.
- Encoder decode:
  - Evaluated every tick using the 2-bit Gray state {A,B}.
  - The valid transitions 00->01->11->10->00 count as CW; the reverse sequence counts as CCW.
  - Invalid double-bit jumps are ignored.
  - Each encoder has a signed 3-bit step accumulator that saturates at +3 and -3. Emitting an event moves the accumulator one step toward 0.
- Event codes:
  - Key k press = {1'b1, k}; key k release = {1'b0, k}.
  - Encoder e CW = {1'b1, NUM_KEYS+2e}; encoder e CCW = {1'b1, NUM_KEYS+2e+1}.
  - Elaboration requires NUM_KEYS + 2*NUM_ENC <= 2**(EV_W-1).
- Arbiter:
  - Emits at most one event per clk, and only when the FIFO is not full or is being popped in the same cycle.
  - A round-robin pointer over sources 0..NUM_KEYS+NUM_ENC-1 grants the first pending source at or after the pointer.
  - The pointer then moves to grant+1, wrapping to 0.
  - Under back-pressure, pending state is held, so no key event is lost.
  - ev_ovf is set only when an encoder accumulator is already at ±3 and a further step in the same direction is decoded.
- FIFO:
  - First-word-fall-through: ev_data shows the head combinationally from storage.
  - A write in cycle n is visible with ev_valid = 1 at cycle n+1.
  - Simultaneous read and write when full is allowed; occupancy is unchanged.
  - ev_rd while empty is ignored.
  - Pointers wrap modulo 2**FIFO_AW.
- fifo_clr:
  - Empties the FIFO and clears ev_ovf in the next cycle.
  - A write granted in the same cycle is discarded, and its pending flag is still cleared.
  - Debounce state and encoder accumulators are kept.

Optional Feature:
- Macro KEY_AUTOREPEAT_EN.
- When defined:
  - Adds parameters REP_DELAY (default 40 ticks) and REP_PERIOD (default 8 ticks).
  - Uses a single repeat counter tracking the most recently pressed key that is still held.
  - When the counter expires, pend_press is set again for that key.
  - Releasing the tracked key, or pressing another key, restarts tracking.
- When undefined: no repeat logic is built; each press produces exactly one press event.

Decomposition:
- Package kbd_pkg holds:
  - the event-code helper functions key_code(k, press) and enc_code(e, cw);
  - the Gray-step decode function;
  - the elaboration-check constants.
- One sub-module, event_fifo (parameters EV_W, FIFO_AW), is instantiated once and holds storage, pointers and count.

Test Plan:
1. Reset, then hold keys[5] = 1 for 4 ticks -> one event 8'h85; ev_count = 1 at the next clk.
2. keys[5] glitches high for 2 ticks with DEB_SAMPLES = 4 -> no event.
3. Drive encoder 1 CW through one full cycle (4 transitions) with NUM_KEYS = 32 -> four events 8'hA2.
4. Keep ev_rd = 0 and press 10 keys at once with depth 8 -> FIFO fills with 8 events in round-robin order; pop 2 -> the remaining 2 keys arrive; ev_ovf stays 0.
5. Spin encoder 0 CCW 5 steps while the FIFO is full -> accumulator saturates at -3 and ev_ovf = 1. Then fifo_clr -> ev_valid = 0, ev_ovf = 0, and three 8'hA1 events follow.
6. Pull rst low in the middle of a write burst -> all outputs are 0 immediately. After release, no event appears until new input activity.
